// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisor table, RX state encoding and the
// baud-selector-to-divisor mapping used by both the TX and RX sides.
package uart_pkg;

    localparam int DIV_W          = 14;
    localparam int BAUD_4800_DIV  = 10416;
    localparam int BAUD_9600_DIV  = 5208;
    localparam int BAUD_14400_DIV = 3472;
    localparam int BAUD_19200_DIV = 2604;
    localparam int BAUD_38400_DIV = 1302;
    localparam int BAUD_57600_DIV = 868;
    localparam int DEFAULT_DIV    = 5208;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // Cycles per bit at a 50 MHz system clock; unknown selectors fall back to 9600.
    function automatic logic [DIV_W-1:0] baud_to_div(input logic [16:0] baud);
        case (baud)
            17'd4800:  return DIV_W'(BAUD_4800_DIV);
            17'd9600:  return DIV_W'(BAUD_9600_DIV);
            17'd14400: return DIV_W'(BAUD_14400_DIV);
            17'd19200: return DIV_W'(BAUD_19200_DIV);
            17'd38400: return DIV_W'(BAUD_38400_DIV);
            17'd57600: return DIV_W'(BAUD_57600_DIV);
            default:   return DIV_W'(DEFAULT_DIV);
        endcase
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous level input; flops reset to 1
// so an idle-high serial line does not look like a start bit after reset.
module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_baud.sv
// UART receiver with internal baud timing and mid-bit sampling.
// Optional even-parity bit between data and stop: define UART_RX_PARITY_EN.
module uart_rx_baud
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [16:0]          baud,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int IDX_W = $clog2(DATA_BITS + 1);

    rx_state_t            r_state;
    rx_state_t            w_state_next;
    logic [DIV_W-1:0]     r_cnt;
    logic [DIV_W-1:0]     r_bit_max;
    logic [DATA_BITS-1:0] r_shift;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;

    logic             w_rx_s;
    logic [DIV_W-1:0] w_half;
    logic             w_half_hit;
    logic             w_bit_hit;
    logic             w_sample;
    logic             w_cnt_clr;
    logic             w_valid_next;
    logic             w_ferr_next;

    uart_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (rx),
        .o_sync  (w_rx_s)
    );

    assign w_half     = r_bit_max >> 1;
    assign w_half_hit = (r_cnt == w_half - DIV_W'(1));
    assign w_bit_hit  = (r_cnt == r_bit_max - DIV_W'(1));

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic w_perr_next;
    logic r_parity_err;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sample     = 1'b0;
        w_valid_next = 1'b0;
        w_ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr_next  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (!w_rx_s) w_state_next = START;
            end
            START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (w_half_hit) w_state_next = w_rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (w_bit_hit) begin
                    w_sample = 1'b1;
                    if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end
                end
            end
            PARITY: begin
                if (w_bit_hit) w_state_next = STOP;
            end
            STOP: begin
                if (w_bit_hit) begin
                    if (w_rx_s) begin
                        w_state_next = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (r_par_bad) w_perr_next = 1'b1;
                        else           w_valid_next = 1'b1;
`else
                        w_valid_next = 1'b1;
`endif
                    end else begin
                        w_ferr_next  = 1'b1;
                        w_state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (w_rx_s) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        w_cnt_clr = (w_state_next != r_state) || w_sample ||
                    ((r_state == PARITY) && w_bit_hit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_bit_max   <= '0;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= w_valid_next;
            r_frame_err <= w_ferr_next;

            if (w_cnt_clr || (r_state == IDLE) || (r_state == BREAK)) r_cnt <= '0;
            else                                                       r_cnt <= r_cnt + DIV_W'(1);

            // Divisor is frozen for the whole frame.
            if ((r_state == IDLE) && (w_state_next != IDLE)) r_bit_max <= baud_to_div(baud);

            if ((r_state == START) && (w_state_next == DATA)) r_bit_idx <= '0;
            else if (w_sample)                                r_bit_idx <= r_bit_idx + IDX_W'(1);

            if (w_sample) r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};

            if (w_valid_next) r_rx_data <= r_shift;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_perr_next;
            // Even parity: data bits plus parity bit must XOR to zero.
            if ((r_state == PARITY) && w_bit_hit) r_par_bad <= (^r_shift) ^ w_rx_s;
        end
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != IDLE);

endmodule
